// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, ROM drive and in-order fetch queue
// Redirect has top priority and empties the queue; a full queue blocks fetch even on a same-cycle pop.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      rom_ce_o,
  output logic [31:0]               rom_addr_o,
  input  logic [31:0]               rom_inst_i,
  input  logic                      redirect_i,
  input  logic [31:0]               redirect_pc_i,
  input  logic                      id_ready_i,
  output logic                      id_valid_o,
  output logic [31:0]               id_pc_o,
  output logic [31:0]               id_inst_o,
  output logic [$clog2(QDEPTH):0]   q_count_o
);

  localparam int           PW   = $clog2(QDEPTH);
  localparam logic [PW:0]  FULL = (PW+1)'(QDEPTH);

  logic [31:0]   pc;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW:0]   count;
  logic [31:0]   pc_mem   [QDEPTH];
  logic [31:0]   inst_mem [QDEPTH];
  logic          fetch;
  logic          pop;

  // Fetch depends only on registered count, redirect and reset, never on id_ready_i.
  assign fetch      = (count < FULL) && !redirect_i && rst;
  assign pop        = id_valid_o && id_ready_i && !redirect_i;

  assign rom_ce_o   = fetch;
  assign rom_addr_o = pc;
  assign id_valid_o = (count != '0);
  assign id_pc_o    = id_valid_o ? pc_mem[rptr]   : 32'h0;
  assign id_inst_o  = id_valid_o ? inst_mem[rptr] : 32'h0;
  assign q_count_o  = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc    <= RESET_PC;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (redirect_i) begin
      pc    <= redirect_pc_i & 32'hFFFF_FFFC;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (fetch) begin
        pc   <= pc + 32'd4;
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({fetch, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever count is zero.
  always_ff @(posedge clk) begin
    if (fetch) begin
      pc_mem[wptr]   <= pc;
      inst_mem[wptr] <= rom_inst_i;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a queue-based reference model
module tb_fetch_unit;

  localparam int          QDEPTH   = 4;
  localparam int          CW       = $clog2(QDEPTH) + 1;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rom_ce;
  logic [31:0]   rom_addr;
  logic [31:0]   rom_inst;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = 32'h0;
  logic          id_ready = 1'b0;
  logic          id_valid;
  logic [31:0]   id_pc;
  logic [31:0]   id_inst;
  logic [CW-1:0] q_count;
  logic          rom_mode = 1'b1;

  int errors = 0;
  int checks = 0;

  ent_t        mq[$];
  logic [31:0] mpc;
  logic [100:0] exp_vec;
  logic [100:0] dut_vec;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_f(input logic mode, input logic [31:0] a);
    if (mode) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign rom_inst = rom_f(rom_mode, rom_addr);

  fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_ce_o     (rom_ce),
    .rom_addr_o   (rom_addr),
    .rom_inst_i   (rom_inst),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .id_ready_i   (id_ready),
    .id_valid_o   (id_valid),
    .id_pc_o      (id_pc),
    .id_inst_o    (id_inst),
    .q_count_o    (q_count)
  );

  // Drive one cycle of inputs, snapshot expected vs observed outputs, then advance the model.
  task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy);
    logic          e_ce, e_valid;
    logic [31:0]   e_pc, e_inst;
    ent_t          e;
    @(negedge clk);
    rst = 1'b1; redirect = rd; redirect_pc = rpc; id_ready = rdy;
    #1;
    e_ce    = (mq.size() < QDEPTH) && !rd;
    e_valid = (mq.size() != 0);
    e_pc    = e_valid ? mq[0].pc   : 32'h0;
    e_inst  = e_valid ? mq[0].inst : 32'h0;
    exp_vec = {e_ce, mpc, e_valid, e_pc, e_inst, CW'(mq.size())};
    dut_vec = {rom_ce, rom_addr, id_valid, id_pc, id_inst, q_count};
    if (rd) begin
      mq.delete();
      mpc = {rpc[31:2], 2'b00};
    end else begin
      if (e_valid && rdy) e = mq.pop_front();
      if (e_ce) begin
        e.pc = mpc;
        e.inst = rom_f(rom_mode, mpc);
        mq.push_back(e);
        mpc = mpc + 32'd4;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    mq.delete();
    mpc = RESET_PC;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({rom_ce, rom_addr, id_valid, id_pc, id_inst, q_count} !== {1'b0, RESET_PC, 1'b0, 64'h0, CW'(0)}) begin
      errors++;
      $display("FAIL reset got ce=%b addr=%h v=%b pc=%h inst=%h cnt=%0d", rom_ce, rom_addr, id_valid, id_pc, id_inst, q_count);
    end
  endtask

  task automatic test_stream();
    rom_mode = 1'b1;
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 32'h0, 1'b1);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL stream[%0d] got=%h exp=%h", i, dut_vec, exp_vec);
      end
    end
    checks++;
    if (q_count !== CW'(1) || id_pc !== 32'h28 || rom_addr !== 32'h2C) begin
      errors++;
      $display("FAIL stream_steady got cnt=%0d pc=%h addr=%h exp cnt=1 pc=28 addr=2c", q_count, id_pc, rom_addr);
    end
  endtask

  task automatic test_fill_drain();
    rom_mode = 1'b0;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 32'h0, 1'b0);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL fill[%0d] got=%h exp=%h", i, dut_vec, exp_vec);
      end
    end
    checks++;
    if (rom_ce !== 1'b0 || q_count !== CW'(4) || rom_addr !== 32'h10 || id_pc !== 32'h0) begin
      errors++;
      $display("FAIL fill_full got ce=%b cnt=%0d addr=%h head=%h exp ce=0 cnt=4 addr=10 head=0", rom_ce, q_count, rom_addr, id_pc);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'h0, 1'b1);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL drain[%0d] got=%h exp=%h", i, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_redirect();
    rom_mode = 1'b0;
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h0000_0103, 1'b1);
    checks++;
    if (dut_vec !== exp_vec) begin
      errors++;
      $display("FAIL redirect_cycle got=%h exp=%h", dut_vec, exp_vec);
    end
    step(1'b0, 32'h0, 1'b1);
    checks++;
    if (rom_ce !== 1'b1 || q_count !== CW'(0) || rom_addr !== 32'h100 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_next got ce=%b cnt=%0d addr=%h v=%b exp ce=1 cnt=0 addr=100 v=0", rom_ce, q_count, rom_addr, id_valid);
    end
    step(1'b0, 32'h0, 1'b1);
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h100 || q_count !== CW'(1)) begin
      errors++;
      $display("FAIL redirect_head got v=%b pc=%h cnt=%0d exp v=1 pc=100 cnt=1", id_valid, id_pc, q_count);
    end
    step(1'b1, 32'h0000_0200, 1'b0);
    step(1'b1, 32'h0000_0305, 1'b1);
    checks++;
    if (dut_vec !== exp_vec) begin
      errors++;
      $display("FAIL b2b_redirect got=%h exp=%h", dut_vec, exp_vec);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b1);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL b2b_after[%0d] got=%h exp=%h", i, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_full_pop();
    rom_mode = 1'b0;
    apply_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    checks++;
    if (rom_ce !== 1'b0 || q_count !== CW'(4) || dut_vec !== exp_vec) begin
      errors++;
      $display("FAIL full_pop got ce=%b cnt=%0d exp ce=0 cnt=4", rom_ce, q_count);
    end
    step(1'b0, 32'h0, 1'b0);
    checks++;
    if (rom_ce !== 1'b1 || q_count !== CW'(3) || rom_addr !== 32'h10 || id_pc !== 32'h4) begin
      errors++;
      $display("FAIL full_pop_next got ce=%b cnt=%0d addr=%h head=%h exp ce=1 cnt=3 addr=10 head=4", rom_ce, q_count, rom_addr, id_pc);
    end
  endtask

  task automatic test_wrap();
    rom_mode = 1'b0;
    step(1'b1, 32'hFFFF_FFFE, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    checks++;
    if (rom_addr !== 32'hFFFF_FFFC || rom_ce !== 1'b1) begin
      errors++;
      $display("FAIL wrap_top got addr=%h ce=%b exp addr=fffffffc ce=1", rom_addr, rom_ce);
    end
    step(1'b0, 32'h0, 1'b1);
    checks++;
    if (rom_addr !== 32'h0 || id_pc !== 32'hFFFF_FFFC || dut_vec !== exp_vec) begin
      errors++;
      $display("FAIL wrap_next got addr=%h head=%h exp addr=0 head=fffffffc", rom_addr, id_pc);
    end
  endtask

  task automatic test_async_reset();
    rom_mode = 1'b0;
    apply_reset();
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #2;
    checks++;
    if (q_count !== CW'(2)) begin
      errors++;
      $display("FAIL async_pre got cnt=%0d exp 2", q_count);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({rom_ce, rom_addr, id_valid, id_pc, id_inst, q_count} !== {1'b0, RESET_PC, 1'b0, 64'h0, CW'(0)}) begin
      errors++;
      $display("FAIL async_reset got ce=%b addr=%h v=%b pc=%h inst=%h cnt=%0d", rom_ce, rom_addr, id_valid, id_pc, id_inst, q_count);
    end
    mq.delete();
    mpc = RESET_PC;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b1);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL async_after[%0d] got=%h exp=%h", i, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    logic        rd, rdy;
    logic [31:0] rpc;
    rom_mode = 1'b0;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      rd  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(rd, rpc, rdy);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL random[%0d] got=%h exp=%h", i, dut_vec, exp_vec);
      end
    end
  endtask

  initial begin
    mpc = RESET_PC;
    test_reset();
    test_stream();
    test_fill_drain();
    test_redirect();
    test_full_pop();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
